npu_result_drain: RTL and testbench

- Downstream stage of the NPU core. Consumes the flattened ARRAY_SIZE x ARRAY_SIZE accumulator tile on result_valid.
- Requantizes each element to OUT_WIDTH signed: shift, round, optional ReLU, saturate.
- Streams the tile out one row per beat over a valid/ready interface with a writeback address, for the unified-buffer write port or a host FIFO.

---
 rtl/npu_result_drain_pkg.sv | 28 ++
 rtl/npu_result_drain_if.sv | 24 ++
 rtl/npu_requant_lane.sv | 42 ++++
 rtl/npu_result_drain.sv | 151 +++++++++++++++
 tb/tb_npu_result_drain.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_result_drain_pkg.sv
// Shared types and helpers for the NPU result drain: FSM state encoding,
// output element bounds and the flat tile index used to address the snapshot.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package npu_drain_pkg;

  typedef enum logic [0:0] {
    DRAIN_IDLE = 1'b0,
    DRAIN_EMIT = 1'b1
  } drain_state_e;

  localparam int DRAIN_OUT_WIDTH = 8;
  localparam int ELEM_MAX = (1 << (DRAIN_OUT_WIDTH - 1)) - 1;
  localparam int ELEM_MIN = -(1 << (DRAIN_OUT_WIDTH - 1));

  function automatic int flat_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/npu_result_drain_if.sv
// Row-beat stream from the result drain to the unified-buffer write port or a host FIFO.
// Handshake: a beat transfers on a rising clk edge where out_valid & out_ready; once
// out_valid is high, out_data/out_addr/out_last hold stable until that transfer.
interface npu_result_drain_if #(
  parameter int N          = 4,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                      out_valid;
  logic                      out_ready;
  logic [N*OUT_WIDTH-1:0]    out_data;
  logic [ADDR_WIDTH-1:0]     out_addr;
  logic                      out_last;

  modport master (
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/npu_requant_lane.sv
// Single-element requantizer: rounding arithmetic right shift, optional ReLU and
// saturation to a signed OUT_WIDTH result, flagging when saturation clipped the value.
module npu_requant_lane
  import npu_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = DRAIN_OUT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] x_i,
  input  logic [4:0]           shift_i,
  input  logic                 relu_i,
  output logic [OUT_WIDTH-1:0] y_o,
  output logic                 sat_o
);
  // One extra bit keeps the rounding increment from overflowing the accumulator range.
  localparam int W1 = ACC_WIDTH + 1;
  localparam logic signed [W1-1:0] MAXV = W1'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [W1-1:0] MINV = ~MAXV;

  logic signed [W1-1:0] xe;
  logic signed [W1-1:0] rnd;
  logic signed [W1-1:0] sum;
  logic signed [W1-1:0] y;

  always_comb begin
    xe  = signed'({x_i[ACC_WIDTH-1], x_i});
    rnd = '0;
    if (shift_i != 5'd0) rnd = W1'(1) << (shift_i - 5'd1);
    sum = xe + rnd;
    y   = sum >>> shift_i;
    if (relu_i && y[W1-1]) y = '0;
    sat_o = 1'b0;
    y_o   = y[OUT_WIDTH-1:0];
    if (y > MAXV) begin
      y_o   = MAXV[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end else if (y < MINV) begin
      y_o   = MINV[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/npu_result_drain.sv
// Captures an accumulator tile, requantizes it and streams it out one row per beat.
// Optional macro NPU_DRAIN_SATSTAT_EN adds sat_count_o, a saturating count of clipped elements.
module npu_result_drain
  import npu_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = `ARRAY_SIZE,
  parameter int ACC_WIDTH  = `ACC_WIDTH,
  parameter int OUT_WIDTH  = DRAIN_OUT_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] results_flat_i,
  input  logic                                     result_valid_i,
  input  logic [4:0]                               shift_amt_i,
  input  logic                                     relu_en_i,
  input  logic [ADDR_WIDTH-1:0]                    base_addr_i,
  input  logic                                     clr_overrun_i,
  npu_result_drain_if.master                       out_if,
  output logic                                     busy_o,
  output logic                                     overrun_o,
  output drain_state_e                             state_o
`ifdef NPU_DRAIN_SATSTAT_EN
  ,
  output logic [15:0]                              sat_count_o
`endif
);
  localparam int N  = ARRAY_SIZE;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = N * N * ACC_WIDTH;

  drain_state_e           state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [TW-1:0]          tile_q, tile_d;
  logic [4:0]             shift_q, shift_d;
  logic                   relu_q, relu_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic                   overrun_q, overrun_d;

  logic                   hs, last_row, last_hs, capture, drop;
  logic [N*OUT_WIDTH-1:0] row_data;
  logic [N-1:0]           sat_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DRAIN_IDLE;
      row_q     <= '0;
      tile_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      base_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      tile_q    <= tile_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      base_q    <= base_d;
      overrun_q <= overrun_d;
    end
  end

  // A strobe on the final handshake is a legal back-to-back capture, not a drop.
  always_comb begin
    hs       = out_if.out_valid & out_if.out_ready;
    last_row = (row_q == RW'(N - 1));
    last_hs  = hs & last_row;
    capture  = result_valid_i & ((state_q == DRAIN_IDLE) | last_hs);
    drop     = result_valid_i & (state_q == DRAIN_EMIT) & ~last_hs;

    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      DRAIN_IDLE: begin
        row_d = '0;
        if (result_valid_i) state_d = DRAIN_EMIT;
      end
      DRAIN_EMIT: begin
        if (last_hs) begin
          row_d = '0;
          if (!result_valid_i) state_d = DRAIN_IDLE;
        end else if (hs) begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase

    tile_d  = capture ? results_flat_i : tile_q;
    shift_d = capture ? shift_amt_i    : shift_q;
    relu_d  = capture ? relu_en_i      : relu_q;
    base_d  = capture ? base_addr_i    : base_q;

    overrun_d = overrun_q;
    if (drop)               overrun_d = 1'b1;
    else if (clr_overrun_i) overrun_d = 1'b0;
  end

  for (genvar c = 0; c < N; c++) begin : g_lane
    npu_requant_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .x_i     (tile_q[flat_idx(int'(row_q), c, N)*ACC_WIDTH +: ACC_WIDTH]),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .y_o     (row_data[c*OUT_WIDTH +: OUT_WIDTH]),
      .sat_o   (sat_flags[c])
    );
  end

  always_comb begin
    out_if.out_valid = (state_q == DRAIN_EMIT);
    out_if.out_last  = (state_q == DRAIN_EMIT) & last_row;
    out_if.out_addr  = '0;
    out_if.out_data  = '0;
    if (state_q == DRAIN_EMIT) begin
      out_if.out_addr = base_q + ADDR_WIDTH'(row_q);
      out_if.out_data = row_data;
    end
    busy_o    = (state_q == DRAIN_EMIT);
    overrun_o = overrun_q;
    state_o   = state_q;
  end

`ifdef NPU_DRAIN_SATSTAT_EN
  logic [15:0] sat_q, sat_d, sat_beats;
  logic [16:0] sat_sum;

  // Counted only at the handshake so a stalled beat contributes once.
  always_comb begin
    sat_beats = '0;
    for (int c = 0; c < N; c++) sat_beats = sat_beats + 16'(sat_flags[c]);
    sat_sum = {1'b0, sat_q} + {1'b0, sat_beats};
    sat_d   = sat_q;
    if (clr_overrun_i) sat_d = '0;
    else if (hs)       sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= '0;
    else     sat_q <= sat_d;
  end

  assign sat_count_o = sat_q;
`else
  logic sat_unused;
  assign sat_unused = |sat_flags;
`endif
endmodule

// File: tb/tb_npu_result_drain.sv
// Directed bench for npu_result_drain: scoreboard of expected row beats checked by a
// monitor, plus direct checks of latency, backpressure, overrun, back-to-back and reset.
module tb_npu_result_drain;
  import npu_drain_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int ADW = 16;
  localparam int DW  = N * OW;
  localparam int EW  = ADW + 1 + DW;

  typedef int tile_vals_t[16];

  logic                clk = 1'b0;
  logic                rst;
  logic [N*N*AW-1:0]   results_flat_i;
  logic                result_valid_i;
  logic [4:0]          shift_amt_i;
  logic                relu_en_i;
  logic [ADW-1:0]      base_addr_i;
  logic                clr_overrun_i;
  logic                busy_o;
  logic                overrun_o;
  drain_state_e        state_o;
`ifdef NPU_DRAIN_SATSTAT_EN
  logic [15:0]         sat_count_o;
`endif

  logic [N*N*AW-1:0]   tile_v;
  logic [EW-1:0]       exp_q[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  beats  = 0;
  int                  b0;

  npu_result_drain_if #(.N(N), .OUT_WIDTH(OW), .ADDR_WIDTH(ADW)) drain_if ();

  npu_result_drain #(
    .ARRAY_SIZE (N),
    .ACC_WIDTH  (AW),
    .OUT_WIDTH  (OW),
    .ADDR_WIDTH (ADW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .results_flat_i (results_flat_i),
    .result_valid_i (result_valid_i),
    .shift_amt_i    (shift_amt_i),
    .relu_en_i      (relu_en_i),
    .base_addr_i    (base_addr_i),
    .clr_overrun_i  (clr_overrun_i),
    .out_if         (drain_if),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .state_o        (state_o)
`ifdef NPU_DRAIN_SATSTAT_EN
    ,
    .sat_count_o    (sat_count_o)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input tile_vals_t v);
    for (int i = 0; i < 16; i++) tile_v[i*AW +: AW] = v[i];
  endtask

  task automatic load_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        tile_v[(r*N+c)*AW +: AW] = r * N + c;
  endtask

  task automatic push_row(input logic [ADW-1:0] addr, input logic last, input logic [DW-1:0] data);
    exp_q.push_back({addr, last, data});
  endtask

  task automatic push_tile(input logic [ADW-1:0] base, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                           input logic [DW-1:0] d3);
    push_row(base,              1'b0, d0);
    push_row(base + ADW'(1),    1'b0, d1);
    push_row(base + ADW'(2),    1'b0, d2);
    push_row(base + ADW'(3),    1'b1, d3);
  endtask

  task automatic strobe(input logic [4:0] s, input logic relu, input logic [ADW-1:0] base);
    results_flat_i = tile_v;
    shift_amt_i    = s;
    relu_en_i      = relu;
    base_addr_i    = base;
    result_valid_i = 1'b1;
    step();
    result_valid_i = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_overrun_i = 1'b1;
    step();
    clr_overrun_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) break;
      step();
    end
    check("idle_reached", 64'(busy_o), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && drain_if.out_valid && drain_if.out_ready) begin
      logic [EW-1:0] act, exp;
      beats++;
      act = {drain_if.out_addr, drain_if.out_last, drain_if.out_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got %h expected no beat", act);
      end else begin
        exp = exp_q.pop_front();
        check("beat", 64'(act), 64'(exp));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tile_vals_t ta, tc;
    ta = '{24, -24, 4000, -4000, 15, -8, 7, 8, 0, 16, -9, 1000, -17, 17, 2047, -2048};
    tc = '{200, -200, 127, -128, 1000, 0, 0, 0, 0, 0, -129, 128, 0, 0, 0, 0};

    rst = 1'b1;
    results_flat_i = '0; result_valid_i = 1'b0; shift_amt_i = '0; relu_en_i = 1'b0;
    base_addr_i = '0; clr_overrun_i = 1'b0; drain_if.out_ready = 1'b0; tile_v = '0;
    repeat (3) step();
    check("rst_valid", 64'(drain_if.out_valid), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_overrun", 64'(overrun_o), 64'd0);
    check("rst_data", 64'(drain_if.out_data), 64'd0);
    check("rst_addr", 64'(drain_if.out_addr), 64'd0);
    check("rst_state", 64'(state_o), 64'(DRAIN_IDLE));
    rst = 1'b0;
    step();

    // identity tile, s=0
    drain_if.out_ready = 1'b1;
    load_identity();
    push_tile(16'h0100, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    strobe(5'd0, 1'b0, 16'h0100);
    check("latency_valid", 64'(drain_if.out_valid), 64'd1);
    check("first_addr", 64'(drain_if.out_addr), 64'h100);
    check("first_last", 64'(drain_if.out_last), 64'd0);
    wait_idle();

    // rounding / saturation, s=4, without and with ReLU
    load_tile(ta);
    push_tile(16'h0200, 32'h807FFF02, 32'h01000001, 32'h3FFF0100, 32'h807F01FF);
    strobe(5'd4, 1'b0, 16'h0200);
    wait_idle();
    push_tile(16'h0300, 32'h007F0002, 32'h01000001, 32'h3F000100, 32'h007F0100);
    strobe(5'd4, 1'b1, 16'h0300);
    wait_idle();

    // backpressure on row 2 with address wrap
    load_identity();
    push_tile(16'hFFFE, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    b0 = beats;
    strobe(5'd0, 1'b0, 16'hFFFE);
    step();
    step();
    drain_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 64'(drain_if.out_valid), 64'd1);
      check("stall_data", 64'(drain_if.out_data), 64'h0B0A0908);
      check("stall_addr", 64'(drain_if.out_addr), 64'h0000);
    end
    drain_if.out_ready = 1'b1;
    wait_idle();
    check("stall_beats", 64'(beats - b0), 64'd4);

    // overrun: strobe during row 1 is dropped
    load_tile(ta);
    push_tile(16'h0400, 32'h807FFF02, 32'h01000001, 32'h3FFF0100, 32'h807F01FF);
    strobe(5'd4, 1'b0, 16'h0400);
    step();
    load_identity();
    strobe(5'd0, 1'b1, 16'h0999);
    check("overrun_set", 64'(overrun_o), 64'd1);
    check("overrun_addr", 64'(drain_if.out_addr), 64'h0402);
    wait_idle();
    check("overrun_sticky", 64'(overrun_o), 64'd1);
    clr_pulse();
    check("overrun_clr", 64'(overrun_o), 64'd0);

    // back-to-back on last-beat handshake
    load_identity();
    push_tile(16'h0500, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    strobe(5'd0, 1'b0, 16'h0500);
    repeat (3) step();
    check("b2b_last", 64'(drain_if.out_last), 64'd1);
    load_tile(ta);
    push_tile(16'h0600, 32'h007F0002, 32'h01000001, 32'h3F000100, 32'h007F0100);
    strobe(5'd4, 1'b1, 16'h0600);
    check("b2b_busy", 64'(busy_o), 64'd1);
    check("b2b_addr", 64'(drain_if.out_addr), 64'h0600);
    check("b2b_no_overrun", 64'(overrun_o), 64'd0);
    // drop coinciding with clear: set wins
    clr_overrun_i = 1'b1;
    load_identity();
    strobe(5'd0, 1'b0, 16'h0777);
    clr_overrun_i = 1'b0;
    check("set_wins", 64'(overrun_o), 64'd1);
    wait_idle();
    clr_pulse();

    // reset mid-tile at row 2
    load_identity();
    push_row(16'h0700, 1'b0, 32'h03020100);
    push_row(16'h0701, 1'b0, 32'h07060504);
    strobe(5'd0, 1'b0, 16'h0700);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(drain_if.out_valid), 64'd0);
    check("rst_mid_state", 64'(state_o), 64'(DRAIN_IDLE));
    check("rst_mid_data", 64'(drain_if.out_data), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_mid_queue", 64'(exp_q.size()), 64'd0);
    push_tile(16'h0710, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    strobe(5'd0, 1'b0, 16'h0710);
    check("post_rst_addr", 64'(drain_if.out_addr), 64'h0710);
    wait_idle();

`ifdef NPU_DRAIN_SATSTAT_EN
    clr_pulse();
    check("sat_cleared", 64'(sat_count_o), 64'd0);
    load_tile(tc);
    push_tile(16'h0800, 32'h807F807F, 32'h0000007F, 32'h7F800000, 32'h00000000);
    strobe(5'd0, 1'b0, 16'h0800);
    drain_if.out_ready = 1'b0;
    step();
    step();
    drain_if.out_ready = 1'b1;
    wait_idle();
    check("sat_count", 64'(sat_count_o), 64'd5);
    clr_pulse();
    check("sat_clr", 64'(sat_count_o), 64'd0);
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
